// File: rtl/nes_responder.sv
// Device-side NES controller (4021-style): serialises btns_in onto nes_data under host latch/pulse.
// Optional glitch filter on the synchronised pins: define NES_RESP_GLITCH_FILTER_EN.
module nes_responder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_CYCLES  = 8,
  parameter int CNTR_WIDTH     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btns_in,
  input  logic       nes_latch,
  input  logic       nes_pulse,
  output logic       nes_data,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [CNTR_WIDTH-1:0] TMO_LAST = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [7:0]            r_shreg;
  logic [2:0]            r_bit_cnt;
  logic [CNTR_WIDTH-1:0] r_tmo;
  logic                  r_nes_data;
  logic                  r_frame_done;

  logic r_lat_s1, r_lat_s2, r_pul_s1, r_pul_s2;
  logic r_lat_d, r_pul_d;
  logic w_lat_s, w_pul_s;
  logic w_lat_rise, w_pul_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat_s1 <= 1'b0;
      r_lat_s2 <= 1'b0;
      r_pul_s1 <= 1'b0;
      r_pul_s2 <= 1'b0;
    end else begin
      r_lat_s1 <= nes_latch;
      r_lat_s2 <= r_lat_s1;
      r_pul_s1 <= nes_pulse;
      r_pul_s2 <= r_pul_s1;
    end
  end

`ifdef NES_RESP_GLITCH_FILTER_EN
  localparam logic [CNTR_WIDTH-1:0] FILT_LAST = CNTR_WIDTH'(FILTER_CYCLES - 1);

  logic                  r_lat_f, r_pul_f;
  logic [CNTR_WIDTH-1:0] r_lat_fc, r_pul_fc;

  // A new level is adopted only once it has been seen FILTER_CYCLES samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat_f  <= 1'b0;
      r_pul_f  <= 1'b0;
      r_lat_fc <= '0;
      r_pul_fc <= '0;
    end else begin
      if (r_lat_s2 == r_lat_f) begin
        r_lat_fc <= '0;
      end else if (r_lat_fc == FILT_LAST) begin
        r_lat_f  <= r_lat_s2;
        r_lat_fc <= '0;
      end else begin
        r_lat_fc <= r_lat_fc + CNT_ONE;
      end
      if (r_pul_s2 == r_pul_f) begin
        r_pul_fc <= '0;
      end else if (r_pul_fc == FILT_LAST) begin
        r_pul_f  <= r_pul_s2;
        r_pul_fc <= '0;
      end else begin
        r_pul_fc <= r_pul_fc + CNT_ONE;
      end
    end
  end

  assign w_lat_s = r_lat_f;
  assign w_pul_s = r_pul_f;
`else
  assign w_lat_s = r_lat_s2;
  assign w_pul_s = r_pul_s2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat_d <= 1'b0;
      r_pul_d <= 1'b0;
    end else begin
      r_lat_d <= w_lat_s;
      r_pul_d <= w_pul_s;
    end
  end

  assign w_lat_rise = w_lat_s & ~r_lat_d;
  assign w_pul_rise = w_pul_s & ~r_pul_d;

  // nes_data is written from the value shreg is about to take, so it lands in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shreg      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_tmo        <= '0;
      r_nes_data   <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_nes_data <= 1'b1;
          r_bit_cnt  <= 3'd0;
          r_tmo      <= '0;
          if (w_lat_rise) begin
            r_state    <= LOAD;
            r_shreg    <= btns_in;
            r_nes_data <= ~btns_in[7];
          end
        end
        LOAD: begin
          r_tmo     <= '0;
          r_bit_cnt <= 3'd0;
          if (w_lat_s) begin
            r_shreg    <= btns_in;
            r_nes_data <= ~btns_in[7];
          end else begin
            r_state <= SHIFT;
          end
        end
        SHIFT, DONE: begin
          if (w_lat_rise) begin
            r_state    <= LOAD;
            r_shreg    <= btns_in;
            r_nes_data <= ~btns_in[7];
            r_bit_cnt  <= 3'd0;
            r_tmo      <= '0;
          end else if (w_pul_rise) begin
            r_shreg    <= {r_shreg[6:0], 1'b0};
            r_nes_data <= ~r_shreg[6];
            r_tmo      <= '0;
            if (r_state == SHIFT) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd6) begin
                r_frame_done <= 1'b1;
                r_state      <= DONE;
              end
            end
          end else if (r_tmo == TMO_LAST) begin
            r_state    <= IDLE;
            r_nes_data <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_tmo      <= '0;
          end else begin
            r_tmo <= r_tmo + CNT_ONE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_nes_data <= 1'b1;
        end
      endcase
    end
  end

  assign nes_data   = r_nes_data;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_nes_responder.sv
// Directed bench for nes_responder: host latch/pulse sequences with hand-computed nes_data.
module tb_nes_responder;

  localparam int TMO  = 300;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btns_in = 8'h00;
  logic       nes_latch = 1'b0;
  logic       nes_pulse = 1'b0;
  logic       nes_data, busy, frame_done;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int fd0;
  logic [7:0] expv;

  nes_responder #(.TIMEOUT_CYCLES(TMO), .FILTER_CYCLES(8), .CNTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .btns_in(btns_in), .nes_latch(nes_latch),
    .nes_pulse(nes_pulse), .nes_data(nes_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_latch();
    nes_latch = 1'b1;
    wait_n(HOLD);
    nes_latch = 1'b0;
    wait_n(HOLD);
  endtask

  task automatic do_pulse(input int w);
    nes_pulse = 1'b1;
    wait_n(w);
    nes_pulse = 1'b0;
    wait_n(HOLD);
  endtask

  initial begin
    // Reset and idle behaviour
    wait_n(4);
    reset = 1'b0;
    wait_n(20);
    check("idle_data", nes_data, 1);
    check("idle_busy", busy, 0);
    check("idle_fd", fd_cnt, 0);

    // Frame of 8'hA5 with latency check on the latch edge
    btns_in = 8'hA5;
    expv = ~8'hA5;
    nes_latch = 1'b1;
    wait_n(2);
    check("lat_lat2", nes_data, 1);
    wait_n(1);
    check("lat_lat3", nes_data, 0);
    check("a5_busy", busy, 1);
    wait_n(HOLD);
    nes_latch = 1'b0;
    wait_n(HOLD);
    check("a5_bit7", nes_data, expv[7]);
    for (int i = 6; i >= 0; i--) begin
      do_pulse(HOLD);
      if (i == 4) btns_in = 8'h00;
      check($sformatf("a5_bit%0d", i), nes_data, expv[i]);
      if (i > 0) check("a5_fd_pending", fd_cnt, 0);
    end
    check("a5_fd", fd_cnt, 1);
    check("a5_done_busy", busy, 1);

    // 8'hFF, 10 pulses: zeros then released fill
    btns_in = 8'hFF;
    fd0 = fd_cnt;
    do_latch();
    check("ff_bit7", nes_data, 0);
    for (int i = 0; i < 10; i++) begin
      do_pulse(HOLD);
      check($sformatf("ff_p%0d", i + 1), nes_data, (i < 7) ? 0 : 1);
    end
    check("ff_fd_once", fd_cnt, fd0 + 1);

    // Restart mid-frame
    btns_in = 8'h80;
    fd0 = fd_cnt;
    do_latch();
    check("r80_bit7", nes_data, 0);
    for (int i = 0; i < 3; i++) begin
      do_pulse(HOLD);
      check("r80_shift", nes_data, 1);
    end
    btns_in = 8'h01;
    do_latch();
    check("r01_bit7", nes_data, 1);
    for (int i = 0; i < 6; i++) begin
      do_pulse(HOLD);
      check("r01_shift", nes_data, 1);
    end
    check("r01_no_fd", fd_cnt, fd0);
    do_pulse(HOLD);
    check("r01_bit0", nes_data, 0);
    check("r01_fd", fd_cnt, fd0 + 1);

    // Latch and pulse rising together: latch wins, count restarts
    btns_in = 8'hC0;
    fd0 = fd_cnt;
    nes_latch = 1'b1;
    nes_pulse = 1'b1;
    wait_n(HOLD);
    nes_latch = 1'b0;
    nes_pulse = 1'b0;
    wait_n(HOLD);
    check("sim_bit7", nes_data, 0);
    check("sim_busy", busy, 1);
    do_pulse(HOLD);
    check("sim_bit6", nes_data, 0);
    do_pulse(HOLD);
    check("sim_bit5", nes_data, 1);
    for (int i = 0; i < 4; i++) do_pulse(HOLD);
    check("sim_no_fd", fd_cnt, fd0);
    do_pulse(HOLD);
    check("sim_fd", fd_cnt, fd0 + 1);

    // Latch held past timeout never aborts
    nes_latch = 1'b1;
    wait_n(TMO + 20);
    check("load_exempt", busy, 1);
    nes_latch = 1'b0;
    wait_n(HOLD);
    check("load_exit_busy", busy, 1);

    // Timeout after last pulse edge
    do_pulse(HOLD);
    nes_pulse = 1'b1;
    wait_n(TMO + 1);
    check("tmo_before", busy, 1);
    wait_n(3);
    check("tmo_busy", busy, 0);
    check("tmo_data", nes_data, 1);
    nes_pulse = 1'b0;
    wait_n(HOLD);

    // Reset mid-frame
    btns_in = 8'h80;
    fd0 = fd_cnt;
    do_latch();
    do_pulse(HOLD);
    check("rst_pre_busy", busy, 1);
    reset = 1'b1;
    wait_n(1);
    check("rst_data", nes_data, 1);
    check("rst_busy", busy, 0);
    check("rst_fd", fd_cnt, fd0);
    reset = 1'b0;
    wait_n(4);

    // Short glitch on pulse, then a 12-cycle pulse
    btns_in = 8'h40;
    do_latch();
    check("gl_bit7", nes_data, 1);
    do_pulse(3);
`ifdef NES_RESP_GLITCH_FILTER_EN
    check("gl_glitch", nes_data, 1);
    do_pulse(12);
    check("gl_long", nes_data, 0);
`else
    check("gl_glitch", nes_data, 0);
    do_pulse(12);
    check("gl_long", nes_data, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
